// File: rtl/emif_cal_calbus_arbiter.sv
// Two-requester calbus arbiter: sequencer and debug masters share one channel.
// Serialises Avalon-style requests; partial debug writes become read-modify-write.
module emif_cal_calbus_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                    calbus_clk,
    input  logic                    calbus_reset,
    input  logic                    seq_read,
    input  logic                    seq_write,
    input  logic [ADDR_WIDTH-1:0]   seq_address,
    input  logic [DATA_WIDTH-1:0]   seq_wdata,
    output logic                    seq_waitrequest,
    output logic [DATA_WIDTH-1:0]   seq_rdata,
    output logic                    seq_rdata_valid,
    input  logic                    dbg_read,
    input  logic                    dbg_write,
    input  logic [ADDR_WIDTH-1:0]   dbg_address,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    input  logic [DATA_WIDTH/8-1:0] dbg_byteenable,
    output logic                    dbg_waitrequest,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
    output logic                    dbg_rdata_valid,
    output logic                    calbus_read,
    output logic                    calbus_write,
    output logic [ADDR_WIDTH-1:0]   calbus_address,
    output logic [DATA_WIDTH-1:0]   calbus_wdata,
    input  logic [DATA_WIDTH-1:0]   calbus_rdata,
    output logic                    busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        MERGE
    } state_t;

    state_t state;
    state_t state_nxt;

    // last_grant: 1 = debug granted last, 0 = sequencer
    logic last_grant;
    logic seq_req;
    logic dbg_req;
    logic grant_seq;
    logic grant_dbg;
    logic idle_ok;
    logic accept;
    logic discard;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [BE_WIDTH-1:0]   lat_be;
    logic                  lat_write;
    logic                  lat_owner;
    logic                  lat_full;
    logic [3:0]            cnt;
    logic                  cnt_last;
    logic [DATA_WIDTH-1:0] rd_sample;
    logic [DATA_WIDTH-1:0] merged;

    // Round-robin grant and combinational waitrequests
    always_comb begin
        seq_req   = seq_read | seq_write;
        dbg_req   = dbg_read | dbg_write;
        grant_seq = seq_req && (!dbg_req || last_grant);
        grant_dbg = dbg_req && (!seq_req || !last_grant);
        idle_ok   = (state == IDLE) && !calbus_reset;
        accept    = idle_ok && (grant_seq || grant_dbg);
        discard   = grant_dbg && dbg_write && (dbg_byteenable == '0);
        seq_waitrequest = !(idle_ok && grant_seq);
        dbg_waitrequest = !(idle_ok && grant_dbg);
    end

    assign cnt_last = (cnt == 4'd1);
    assign busy     = (state != IDLE);

    // Byte merge of latched write data over the sampled read word
    always_comb begin
        merged = rd_sample;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (lat_be[i]) begin
                merged[8*i +: 8] = lat_wdata[8*i +: 8];
            end
        end
    end

    // Next-state and calbus command outputs
    always_comb begin
        state_nxt      = state;
        calbus_read    = 1'b0;
        calbus_write   = 1'b0;
        calbus_address = '0;
        calbus_wdata   = '0;
        unique case (state)
            IDLE: begin
                if (accept && !discard) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                calbus_address = lat_addr;
                if (lat_write && lat_full) begin
                    calbus_write = 1'b1;
                    calbus_wdata = lat_wdata;
                    state_nxt    = IDLE;
                end else begin
                    calbus_read = 1'b1;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_last) begin
                    state_nxt = lat_write ? MERGE : IDLE;
                end
            end
            MERGE: begin
                calbus_write   = 1'b1;
                calbus_address = lat_addr;
                calbus_wdata   = merged;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and round-robin pointer
    always_ff @(posedge calbus_clk) begin
        if (calbus_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant_dbg;
            end
        end
    end

    // Request capture on accept; a simultaneous read is dropped for the write
    always_ff @(posedge calbus_clk) begin
        if (accept) begin
            lat_owner <= grant_dbg;
            if (grant_dbg) begin
                lat_addr  <= dbg_address;
                lat_wdata <= dbg_wdata;
                lat_be    <= dbg_byteenable;
                lat_write <= dbg_write;
                lat_full  <= (dbg_byteenable == '1);
            end else begin
                lat_addr  <= seq_address;
                lat_wdata <= seq_wdata;
                lat_be    <= '1;
                lat_write <= seq_write;
                lat_full  <= 1'b1;
            end
        end
    end

    // Read latency counter and read-data sampling
    always_ff @(posedge calbus_clk) begin
        if (calbus_reset) begin
            cnt             <= '0;
            rd_sample       <= '0;
            seq_rdata       <= '0;
            dbg_rdata       <= '0;
            seq_rdata_valid <= 1'b0;
            dbg_rdata_valid <= 1'b0;
        end else begin
            seq_rdata_valid <= 1'b0;
            dbg_rdata_valid <= 1'b0;
            if (state == CMD) begin
                cnt <= 4'(RD_LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                if (cnt_last) begin
                    if (lat_write) begin
                        rd_sample <= calbus_rdata;
                    end else if (lat_owner) begin
                        dbg_rdata       <= calbus_rdata;
                        dbg_rdata_valid <= 1'b1;
                    end else begin
                        seq_rdata       <= calbus_rdata;
                        seq_rdata_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/emif_cal_calbus_arbiter.md
# emif_cal_calbus_arbiter

Two-requester arbiter that shares one calibration bus channel between the calibration sequencer master and the calibration debug master. It sits between the IOSSM sequencer or debug logic and one `calbus_*` channel. It serialises their Avalon-style read and write requests onto the single-cycle calbus command protocol with fixed read latency. Debug writes with partial byte enables are performed as a read-modify-write.

## Interface
Parameters:
- `ADDR_WIDTH`, 20: calbus address width.
- `DATA_WIDTH`, 32: calbus data width; must be a multiple of 8.
- `RD_LATENCY`, 2: cycles from the `calbus_read` cycle to valid `calbus_rdata`; legal range 1..15.

Ports:
- `calbus_clk`  in  1  — the single clock.
- `calbus_reset`  in  1  — synchronous, active-high reset.
- `seq_read`, `seq_write`  in  1 each  — sequencer request strobes.
- `seq_address`  in  ADDR_WIDTH; `seq_wdata`  in  DATA_WIDTH  — sequencer command fields; sequencer writes are always full-word.
- `seq_waitrequest`  out  1; `seq_rdata`  out  DATA_WIDTH; `seq_rdata_valid`  out  1.
- `dbg_read`, `dbg_write`  in  1 each; `dbg_address`  in  ADDR_WIDTH; `dbg_wdata`  in  DATA_WIDTH; `dbg_byteenable`  in  DATA_WIDTH/8.
- `dbg_waitrequest`  out  1; `dbg_rdata`  out  DATA_WIDTH; `dbg_rdata_valid`  out  1.
- `calbus_read`, `calbus_write`  out  1 each  — single-cycle command pulses.
- `calbus_address`  out  ADDR_WIDTH; `calbus_wdata`  out  DATA_WIDTH; `calbus_rdata`  in  DATA_WIDTH.
- `busy`  out  1  — high whenever the FSM is not in IDLE.

## Operation
- **Acceptance rule:** a request is accepted in a cycle where its read or write strobe is high and its waitrequest is low.
- **Waitrequest:**
  - `X_waitrequest` is low only when the FSM is in IDLE and requester X wins arbitration.
  - This is combinational from the strobes and `last_grant`.
  - It is high otherwise, including during reset.
- **Arbitration:**
  - Round-robin between the two requesters using the 1-bit register `last_grant`.
  - A lone requester always wins.
  - On a conflict, the requester not granted last wins.
  - `last_grant` updates on every accept.
  - Reset value of `last_grant` is dbg, so seq wins the first conflict.
- **Same-requester conflict:** if one requester raises read and write together, the write is taken and the read is ignored.
- **FSM states:** IDLE, CMD, WAIT, MERGE.
- **IDLE:**
  - On accept, latch address, wdata, byteenable, op and owner, then go to CMD.
  - A debug write with `dbg_byteenable == 0` is accepted and discarded; the FSM stays in IDLE and no calbus activity occurs.
- **CMD:**
  - Drive `calbus_address` for one cycle, together with either `calbus_write` plus `calbus_wdata`, or `calbus_read`.
  - Full write → IDLE.
  - Read, or partial debug write (RMW) → WAIT, loading a 4-bit counter with RD_LATENCY.
- **WAIT:**
  - The counter decrements each cycle.
  - When it reaches 0, `calbus_rdata` is sampled.
  - Read: load the owner's rdata register and pulse the owner's `rdata_valid` the next cycle, which is also back in IDLE.
  - RMW: go to MERGE.
- **MERGE:**
  - Byte i of the write data is the latched `wdata` byte i if `byteenable[i]` is set, else the sampled read byte i.
  - Issue `calbus_write` with the merged data at the latched address → IDLE.
- **Outputs outside command cycles:**
  - `calbus_address` and `calbus_wdata` are 0 in all cycles where neither command strobe is high.
  - `seq_rdata` and `dbg_rdata` hold their last value between valid pulses.
- **Ordering:** at most one transaction is outstanding; completions are strictly in order.

## Timing
- Accept in cycle t → CMD command pulse in t+1.
- Full write: next accept possible at t+2.
- Read: `calbus_read` at t+1, rdata sampled at t+1+RD_LATENCY, `X_rdata_valid` pulse (1 cycle) at t+2+RD_LATENCY.
  - The FSM is in IDLE in that same cycle, so a new accept is possible there.
- RMW: `calbus_read` at t+1, `calbus_write` at t+2+RD_LATENCY, IDLE at t+3+RD_LATENCY.
- **Reset values:**
  - `calbus_read`, `calbus_write`, `calbus_address`, `calbus_wdata`: 0.
  - Both rdata outputs and both rdata_valid outputs: 0.
  - `busy`: 0; both waitrequests: 1.
- **Reset mid-transaction:**
  - Aborts immediately.
  - No `rdata_valid` pulse and no pending RMW write are ever produced.
  - In-flight `calbus_rdata` is ignored.
  - The first accept is possible in the first cycle after reset deasserts.

## Test plan
All scenarios use RD_LATENCY=2.
- **Reset:** hold reset 3 cycles with both requesters strobing.
  - Both waitrequests stay 1; all calbus outputs, rdata, rdata_valid and busy stay 0.
- **Sequencer full write:** seq writes 0xDEADBEEF to 0x00123, accepted at t.
  - `calbus_write`=1 with addr 0x00123 and data 0xDEADBEEF at t+1.
  - `seq_waitrequest`=0 again at t+2.
- **Debug read:** dbg reads 0x00040 at t; the calbus model returns 0xA5A50001 at t+3.
  - `calbus_read` at t+1.
  - `dbg_rdata_valid`=1 with `dbg_rdata`=0xA5A50001 at t+4 only.
- **Conflict arbitration:** after reset, both requesters hold write requests continuously.
  - Grants alternate seq, dbg, seq, dbg at accepts t, t+2, t+4, t+6.
  - Each calbus_write carries the owner's data.
- **Read-modify-write:** memory word 0x11223344 at 0x00010; dbg writes 0xAABBCCDD with byteenable 4'b0101.
  - `calbus_read` at t+1.
  - `calbus_write` at t+4 with data 0x11BB33DD.
  - A byteenable of 0 produces no calbus pulse.
- **Reset during WAIT:** assert reset at t+2 of a dbg read.
  - No `dbg_rdata_valid` pulse ever occurs.
  - A seq write issued after reset completes normally.
